// File: rtl/lcd_pkg.sv
// Shared HD44780 command bytes and state encodings for the 4-bit LCD driver.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_4BIT   = 8'h28;
  localparam logic [7:0] CMD_DISP_ON     = 8'h0C;
  localparam logic [7:0] CMD_DISP_CURSOR = 8'h0F;
  localparam logic [7:0] CMD_ENTRY       = 8'h06;
  localparam logic [7:0] CMD_CLEAR       = 8'h01;
  localparam logic [7:0] ADDR_LINE1      = 8'h80;
  localparam logic [7:0] ADDR_LINE2      = 8'hC0;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_INIT_NIB,
    ST_INIT_CMD,
    ST_LINE1_ADDR,
    ST_LINE1_CHAR,
    ST_LINE2_ADDR,
    ST_LINE2_CHAR
  } lcd_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SETUP,
    TX_HIGH,
    TX_GAP
  } tx_phase_e;

endpackage

// File: rtl/lcd_nibble_tx.sv
// One nibble on the HD44780 4-bit bus: setup, E strobe, then a programmable E-low gap.
// o_done is asserted in the last gap cycle so a start in that cycle follows with no bubble.
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int unsigned T_E_SETUP = 2,
  parameter int unsigned T_E_HIGH  = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_rs,
  input  logic [3:0]  i_nib,
  input  logic [31:0] i_gap,
  output logic        o_rs,
  output logic [3:0]  o_nib,
  output logic        o_e,
  output logic        o_done
);

  tx_phase_e   r_phase, w_phase;
  logic [31:0] r_cnt, w_cnt;
  logic [31:0] r_gap;
  logic        r_rs, r_e, w_e;
  logic [3:0]  r_nib;

  always_comb begin
    w_phase = r_phase;
    w_cnt   = r_cnt + 32'd1;
    w_e     = r_e;
    o_done  = 1'b0;
    case (r_phase)
      TX_SETUP: if (r_cnt == T_E_SETUP - 1) begin
        w_phase = TX_HIGH;
        w_cnt   = '0;
        w_e     = 1'b1;
      end
      TX_HIGH: if (r_cnt == T_E_HIGH - 1) begin
        w_phase = TX_GAP;
        w_cnt   = '0;
        w_e     = 1'b0;
      end
      TX_GAP: if (r_cnt == r_gap - 32'd1) begin
        w_phase = TX_IDLE;
        w_cnt   = '0;
        o_done  = 1'b1;
      end
      default: w_cnt = '0;
    endcase
    if (i_start) begin
      w_phase = TX_SETUP;
      w_cnt   = '0;
      w_e     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= TX_IDLE;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_rs    <= 1'b0;
      r_nib   <= '0;
      r_e     <= 1'b0;
    end else begin
      r_phase <= w_phase;
      r_cnt   <= w_cnt;
      r_e     <= w_e;
      if (i_start) begin
        r_rs  <= i_rs;
        r_nib <= i_nib;
        r_gap <= i_gap;
      end
    end
  end

  assign o_rs  = r_rs;
  assign o_nib = r_nib;
  assign o_e   = r_e;

endmodule

// File: rtl/lcd_hd44780_4bit.sv
// HD44780 4-bit driver: power-up wait, init sequence, then continuous two-line refresh.
// Define LCD_CURSOR_EN to turn on cursor and blink in the display-control byte.
module lcd_hd44780_4bit
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERUP    = 750000,
  parameter int unsigned T_E_SETUP    = 2,
  parameter int unsigned T_E_HIGH     = 12,
  parameter int unsigned T_NIBBLE_GAP = 50,
  parameter int unsigned T_CMD        = 2000,
  parameter int unsigned T_CLEAR      = 82000,
  parameter int unsigned T_INIT_LONG  = 205000,
  parameter int unsigned T_INIT_SHORT = 5000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] chars,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_e,
  output logic         lcd_4,
  output logic         lcd_5,
  output logic         lcd_6,
  output logic         lcd_7,
  output logic         frame_done
);

`ifdef LCD_CURSOR_EN
  localparam logic [7:0] DISP_CTRL = CMD_DISP_CURSOR;
`else
  localparam logic [7:0] DISP_CTRL = CMD_DISP_ON;
`endif

  // r_state/r_idx/r_lo describe the nibble currently on the bus, not the next one
  lcd_state_e   r_state, w_ns;
  logic [3:0]   r_idx, w_nidx;
  logic         r_lo, w_nlo;
  logic [31:0]  r_timer;
  logic [255:0] r_snap;
  logic         r_frame_done;
  logic         w_trig, w_done, w_frame_end, w_rs, w_tx_rs;
  logic [7:0]   w_byte, w_bit1, w_bit2;
  logic [3:0]   w_nib, w_tx_nib;
  logic [31:0]  w_gap;

  always_comb begin
    w_ns        = r_state;
    w_nidx      = r_idx;
    w_nlo       = r_lo;
    w_frame_end = 1'b0;
    w_trig      = (r_state == ST_POWERUP) ? (r_timer == T_POWERUP - 1) : w_done;
    if (w_trig) begin
      case (r_state)
        ST_POWERUP: begin
          w_ns   = ST_INIT_NIB;
          w_nidx = '0;
          w_nlo  = 1'b0;
        end
        ST_INIT_NIB: if (r_idx == 4'd3) begin
          w_ns   = ST_INIT_CMD;
          w_nidx = '0;
        end else w_nidx = r_idx + 4'd1;
        default: if (!r_lo) w_nlo = 1'b1;
        else begin
          w_nlo = 1'b0;
          case (r_state)
            ST_INIT_CMD: if (r_idx == 4'd3) begin
              w_ns   = ST_LINE1_ADDR;
              w_nidx = '0;
            end else w_nidx = r_idx + 4'd1;
            ST_LINE1_ADDR: begin
              w_ns   = ST_LINE1_CHAR;
              w_nidx = '0;
            end
            ST_LINE1_CHAR: if (r_idx == 4'd15) begin
              w_ns   = ST_LINE2_ADDR;
              w_nidx = '0;
            end else w_nidx = r_idx + 4'd1;
            ST_LINE2_ADDR: begin
              w_ns   = ST_LINE2_CHAR;
              w_nidx = '0;
            end
            default: if (r_idx == 4'd15) begin
              w_ns        = ST_LINE1_ADDR;
              w_nidx      = '0;
              w_frame_end = 1'b1;
            end else w_nidx = r_idx + 4'd1;
          endcase
        end
      endcase
    end
  end

  // Column k of a line sits at bit 127-8k, i.e. {~k, 3'b111} within the half
  assign w_bit1 = {1'b1, ~w_nidx, 3'b111};
  assign w_bit2 = {1'b0, ~w_nidx, 3'b111};

  always_comb begin
    w_byte = '0;
    w_rs   = 1'b0;
    case (w_ns)
      ST_INIT_CMD: case (w_nidx)
        4'd0:    w_byte = CMD_FUNC_4BIT;
        4'd1:    w_byte = DISP_CTRL;
        4'd2:    w_byte = CMD_ENTRY;
        default: w_byte = CMD_CLEAR;
      endcase
      ST_LINE1_ADDR: w_byte = ADDR_LINE1;
      ST_LINE2_ADDR: w_byte = ADDR_LINE2;
      ST_LINE1_CHAR: begin
        w_byte = r_snap[w_bit1 -: 8];
        w_rs   = 1'b1;
      end
      ST_LINE2_CHAR: begin
        w_byte = r_snap[w_bit2 -: 8];
        w_rs   = 1'b1;
      end
      default: w_byte = '0;
    endcase
    if (w_ns == ST_INIT_NIB) begin
      w_nib = (w_nidx == 4'd3) ? 4'h2 : 4'h3;
      case (w_nidx)
        4'd0:    w_gap = 32'(T_INIT_LONG);
        4'd1:    w_gap = 32'(T_INIT_SHORT);
        default: w_gap = 32'(T_CMD);
      endcase
    end else begin
      w_nib = w_nlo ? w_byte[3:0] : w_byte[7:4];
      if (!w_nlo)                                      w_gap = 32'(T_NIBBLE_GAP);
      else if (w_ns == ST_INIT_CMD && w_nidx == 4'd3) w_gap = 32'(T_CLEAR);
      else                                             w_gap = 32'(T_CMD);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_POWERUP;
      r_idx        <= '0;
      r_lo         <= 1'b0;
      r_timer      <= '0;
      r_snap       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_ns;
      r_idx        <= w_nidx;
      r_lo         <= w_nlo;
      r_frame_done <= w_frame_end;
      if (r_state == ST_POWERUP) r_timer <= r_timer + 32'd1;
      if (w_ns == ST_LINE1_ADDR && r_state != ST_LINE1_ADDR) r_snap <= chars;
    end
  end

  lcd_nibble_tx #(
    .T_E_SETUP (T_E_SETUP),
    .T_E_HIGH  (T_E_HIGH)
  ) u_tx (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_trig),
    .i_rs    (w_rs),
    .i_nib   (w_nib),
    .i_gap   (w_gap),
    .o_rs    (w_tx_rs),
    .o_nib   (w_tx_nib),
    .o_e     (lcd_e),
    .o_done  (w_done)
  );

  assign lcd_rs     = w_tx_rs;
  assign lcd_rw     = 1'b0;
  assign {lcd_7, lcd_6, lcd_5, lcd_4} = w_tx_nib;
  assign frame_done = r_frame_done;

endmodule
